// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC front end.
// Provides the cartesian word layout and the +/-1.0 fix16_14 saturation helper.
package cordic_pkg;

  typedef struct packed {
    logic signed [15:0] y;
    logic signed [15:0] x;
  } cart_t;

  localparam logic signed [15:0] CORDIC_ONE = 16'sd16384;
  localparam logic signed [15:0] CORDIC_NEG_ONE = -16'sd16384;

  function automatic logic signed [15:0] sat_unit(
    input logic signed [15:0] v
  );
    if (v > CORDIC_ONE) return CORDIC_ONE;
    if (v < CORDIC_NEG_ONE) return CORDIC_NEG_ONE;
    return v;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Generic 2-entry AXI-Stream register slice (output reg + skid reg).
// in_ready comes only from registers, so out_ready never reaches the source.
module axis_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         rdy_q;
  logic         out_v;
  logic [W-1:0] out_d;
  logic         skid_v;
  logic [W-1:0] skid_d;
  logic         push;
  logic         pop;

  assign in_ready  = rdy_q && !(out_v && skid_v);
  assign push      = in_valid && in_ready;
  assign pop       = out_v && out_ready;
  assign out_valid = out_v;
  assign out_data  = out_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdy_q  <= 1'b0;
      out_v  <= 1'b0;
      out_d  <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (!out_v || pop) begin
        if (skid_v) begin
          out_d  <= skid_d;
          out_v  <= 1'b1;
          skid_v <= push;
          if (push) skid_d <= in_data;
        end else begin
          out_v <= push;
          if (push) out_d <= in_data;
        end
      end else if (push) begin
        // output is stalled: park the new pair behind it
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/cordic_cart_packer.sv
// Pairs interleaved X/Y samples into {Y,X} words with frame tlast for CORDIC.
// Optional CART_PACK_CLAMP_EN saturates each sample to +/-1.0 before packing.
module cordic_cart_packer
  import cordic_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        err_misalign
);

  logic               ph;
  logic signed [15:0] x_q;
  logic [CNT_W-1:0]   pair_cnt;
  logic               err_q;
  logic signed [15:0] smp;
  logic               acc;
  logic               last_pair;
  cart_t              word;
  logic [32:0]        buf_out;

`ifdef CART_PACK_CLAMP_EN
  assign smp = sat_unit($signed(s_tdata));
`else
  assign smp = $signed(s_tdata);
`endif

  assign acc       = s_tvalid && s_tready;
  assign last_pair = (pair_cnt == CNT_W'(FRAME_LEN - 1)) || s_tlast;
  assign word      = '{y: smp, x: x_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ph       <= 1'b0;
      x_q      <= '0;
      pair_cnt <= '0;
      err_q    <= 1'b0;
    end else if (acc) begin
      if (!ph) begin
        // tlast on an X means the source lost alignment: drop and resync
        if (s_tlast) begin
          err_q    <= 1'b1;
          pair_cnt <= '0;
        end else begin
          x_q <= smp;
          ph  <= 1'b1;
        end
      end else begin
        ph       <= 1'b0;
        pair_cnt <= last_pair ? '0 : pair_cnt + CNT_W'(1);
      end
    end
  end

  axis_skid_buf #(
    .W(33)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  ({last_pair, word}),
    .in_valid (s_tvalid && ph),
    .in_ready (s_tready),
    .out_data (buf_out),
    .out_valid(m_tvalid),
    .out_ready(m_tready)
  );

  assign m_tlast      = buf_out[32];
  assign m_tdata      = buf_out[31:0];
  assign err_misalign = err_q;

endmodule

// File: tb/tb_cordic_cart_packer.sv
// Self-checking bench for cordic_cart_packer (FRAME_LEN=4).
// Directed table plus random traffic against a queue-based stream model.
module tb_cordic_cart_packer;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        err_misalign;

  cordic_cart_packer #(
    .FRAME_LEN(FL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [32:0] q[$];
  bit          m_ph;
  int          m_cnt;
  bit          m_err;
  logic [15:0] m_x;
  bit          stall_prev;
  logic [32:0] held;

  function automatic logic [15:0] ref_sat(input logic [15:0] d);
    int v;
    v = int'($signed(d));
`ifdef CART_PACK_CLAMP_EN
    if (v > 16384) v = 16384;
    if (v < -16384) v = -16384;
`endif
    return 16'(v);
  endfunction

  task automatic model_accept(input logic [15:0] d,
                              input logic l);
    logic [15:0] s;
    bit last;
    s = ref_sat(d);
    if (!m_ph) begin
      if (l) begin
        m_err = 1;
        m_cnt = 0;
      end else begin
        m_x = s;
        m_ph = 1;
      end
    end else begin
      last = (m_cnt == FL - 1) || l;
      q.push_back({last, s, m_x});
      m_cnt = last ? 0 : m_cnt + 1;
      m_ph = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_ph = 0;
      m_cnt = 0;
      m_err = 0;
      m_x = '0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", {m_tlast, m_tdata}, held);
      end
      chk("err_flag", err_misalign, m_err);
      if (m_tvalid && m_tready) begin
        if (q.size() == 0)
          chk("pop_when_empty", q.size(), 1);
        else
          chk("stream", {m_tlast, m_tdata}, q.pop_front());
      end
      if (s_tvalid && s_tready)
        model_accept(s_tdata, s_tlast);
      stall_prev = m_tvalid && !m_tready;
      held = {m_tlast, m_tdata};
    end
  end

  // ---------------- stimulus helpers ----------------
  // Call in a posedge+1 slot; returns at posedge+1 after acceptance.
  task automatic beat(input logic [15:0] d, input logic l);
    bit ok;
    ok = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (s_tready) ok = 1;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL beat_timeout: got s_tready 0 expected 1");
    end else begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom % 8)
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h4001;
      3: return 16'hBFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] d;
    logic        l;
  } vec_t;

  vec_t tbl[5];
  bit   done;

  initial begin
    tbl[0] = '{16'h1000, 16'h2000, 32'h2000_1000, 1'b0};
    tbl[1] = '{16'h0123, 16'hFEDC, 32'hFEDC_0123, 1'b0};
`ifdef CART_PACK_CLAMP_EN
    tbl[2] = '{16'h7FFF, 16'h8000, 32'hC000_4000, 1'b0};
`else
    tbl[2] = '{16'h7FFF, 16'h8000, 32'h8000_7FFF, 1'b0};
`endif
    tbl[3] = '{16'h0001, 16'h0002, 32'h0002_0001, 1'b1};
    tbl[4] = '{16'h0003, 16'h0004, 32'h0004_0003, 1'b0};

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_err", err_misalign, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rdy_after_rel", s_tready, 1);

    // table: pairing, latency, frame tlast, clamp
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      beat(tbl[i].x, 1'b0);
      beat(tbl[i].y, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), m_tvalid, 1);
      chk($sformatf("tbl%0d_data", i), m_tdata, tbl[i].d);
      chk($sformatf("tbl%0d_last", i), m_tlast, tbl[i].l);
      @(posedge clk);
      #1;
    end

    // tlast on an X sample
    beat(16'h0AAA, 1'b1);
    @(negedge clk);
    chk("mis_err", err_misalign, 1);
    chk("mis_no_out", m_tvalid, 0);
    @(posedge clk);
    #1;
    beat(16'h0111, 1'b0);
    beat(16'h0222, 1'b0);
    @(negedge clk);
    chk("mis_next_data", m_tdata, 32'h0222_0111);
    chk("mis_next_last", m_tlast, 0);
    @(posedge clk);
    #1;
    beat(16'h0100, 1'b0);
    beat(16'h0200, 1'b1);
    @(negedge clk);
    chk("src_tlast", m_tlast, 1);
    @(posedge clk);
    #1;

    // back-pressure: fill both entries, hold, release
    m_tready = 1'b0;
    beat(16'h00A1, 1'b0);
    beat(16'h00A2, 1'b0);
    beat(16'h00B1, 1'b0);
    beat(16'h00B2, 1'b0);
    @(negedge clk);
    chk("bp_full_rdy", s_tready, 0);
    chk("bp_head", m_tdata, 32'h00A2_00A1);
    repeat (10) @(posedge clk);
    #1 m_tready = 1'b1;
    @(negedge clk);
    chk("bp_out1_v", m_tvalid, 1);
    chk("bp_out1_d", m_tdata, 32'h00A2_00A1);
    @(negedge clk);
    chk("bp_out2_v", m_tvalid, 1);
    chk("bp_out2_d", m_tdata, 32'h00B2_00B1);
    @(posedge clk);
    #1;

    // reset after a lone X: next sample is an X again
    beat(16'h0444, 1'b0);
    rst_pulse();
    beat(16'h0555, 1'b0);
    beat(16'h0666, 1'b0);
    @(negedge clk);
    chk("rstx_data", m_tdata, 32'h0666_0555);
    chk("rstx_last", m_tlast, 0);
    @(posedge clk);
    #1;

    // reset with two pairs buffered
    m_tready = 1'b0;
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    beat(16'h3333, 1'b0);
    beat(16'h4444, 1'b0);
    rst_pulse();
    @(negedge clk);
    chk("rstb_valid", m_tvalid, 0);
    chk("rstb_rdy", s_tready, 0);
    @(posedge clk);
    #1 m_tready = 1'b1;

    // random traffic against the model
    done = 0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
          end
          beat(rnd_sample(), ($urandom % 10) == 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if ($urandom % 40 == 0)
            m_tready = 1'b0;
          else if (!m_tready)
            m_tready = ($urandom % 4) == 0;
          else
            m_tready = ($urandom % 5) != 0;
        end
      end
    join
    m_tready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drained", q.size(), 0);
    chk("end_valid", m_tvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
